change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 50000, giving the maximum cycles to wait for each eject_ack edge before declaring a jam.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, giving the idle cycles between consecutive coin ejections.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port start  input  1  one-cycle request to dispense amount.
REQ-007 The block SHALL have port amount  input  8  change to return in credit units, sampled only on an accepted start.
REQ-008 The block SHALL have port eject_ack  input  1  mechanism acknowledge, high while a coin is being released.
REQ-009 The block SHALL have port clear_jam  input  1  one-cycle operator clear of a jam.
REQ-010 The block SHALL have port eject_req  output  1  coin ejection request to mechanism.
REQ-011 The block SHALL have port eject_coin  output  2  denomination: 01=1, 10=2, 11=5, 00=none.
REQ-012 The block SHALL have port remaining  output  8  change still owed.
REQ-013 The block SHALL have port coins_dispensed  output  8  coins ejected in current/last transaction, saturating at 255.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 The block SHALL have port jam_error  output  1  high while in JAM.

Function
REQ-017 The FSM SHALL have the states IDLE, SELECT, REQ, RELEASE, GAP, DONE and JAM; all outputs SHALL be registered.
REQ-018 In IDLE, start=1 with amount>0 SHALL load remaining=amount, clear coins_dispensed to 0, and enter SELECT on the next cycle, so busy=1 at cycle N+1 for start at N.
REQ-019 In IDLE, start=1 with amount=0 SHALL produce done=1 at N+1 with no eject_req, remain in IDLE, and clear coins_dispensed to 0.
REQ-020 In any state other than IDLE, start SHALL be ignored and amount SHALL NOT be resampled.
REQ-021 SELECT SHALL take one cycle and set eject_coin greedily: 11 if remaining>=5, else 10 if remaining>=2, else 01; it then enters REQ, so the first eject_req=1 appears at N+2.
REQ-022 In REQ, eject_req and eject_coin SHALL be held stable until eject_ack is sampled high.
REQ-023 On the REQ cycle where eject_ack=1, remaining SHALL decrease by the coin value (1/2/5) and coins_dispensed SHALL increment; eject_req SHALL be 0 from the next cycle and the state SHALL become RELEASE.
REQ-024 RELEASE SHALL wait for eject_ack=0; then, if remaining=0, it SHALL enter DONE, otherwise GAP.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles with eject_req=0 and eject_coin=00, then enter SELECT.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, set eject_coin=00, and return to IDLE.
REQ-027 A timeout counter SHALL be cleared on entry to REQ and to RELEASE; if it reaches ACK_TIMEOUT while in REQ or RELEASE, the FSM SHALL enter JAM.
REQ-028 In JAM, eject_req SHALL be 0, jam_error and busy SHALL be 1, and remaining and coins_dispensed SHALL hold their values.
REQ-029 In JAM, clear_jam=1 SHALL clear remaining to 0, deassert jam_error, enter IDLE, and produce no done pulse.
REQ-030 clear_jam SHALL have no effect outside JAM.
REQ-031 The remaining count SHALL never underflow: the greedy choice guarantees remaining >= coin value at every decrement.
REQ-032 The timeout counter SHALL be wide enough to hold ACK_TIMEOUT without wrap.

Reset
REQ-033 When rst=1 on a clock edge, the block SHALL enter IDLE from any state, including mid-handshake, with: eject_req=0, eject_coin=00, remaining=0, coins_dispensed=0, busy=0, done=0, jam_error=0, and the timeout and gap counters at 0.
REQ-034 rst SHALL take priority over start, clear_jam and eject_ack.

Verification
REQ-035 The bench SHALL cover: start, amount=8, with the mechanism acking each request after 3 cycles -> coins 11, 10, 01 in order; remaining 8→3→1→0; done pulse once; coins_dispensed=3.
REQ-036 The bench SHALL cover: start, amount=0 -> done=1 the next cycle; eject_req never asserted; busy stays 0.
REQ-037 The bench SHALL cover: start, amount=6, eject_ack held 0 -> JAM after ACK_TIMEOUT cycles in REQ; jam_error=1; remaining=6; then clear_jam -> IDLE with remaining=0 and no done pulse.
REQ-038 The bench SHALL cover: eject_ack stuck at 1 after the first ack (amount=7) -> remaining=2, then JAM from RELEASE after ACK_TIMEOUT cycles.
REQ-039 The bench SHALL cover: a second start with amount=9 while busy on amount=4 -> ignored; total dispensed is 4, as coins 10 then 10.
REQ-040 The bench SHALL cover: rst asserted for one cycle while in REQ -> all outputs at reset values the following cycle; a subsequent start operates normally.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out an owed amount using greedy 5/2/1 coins over an
// ack handshake, with an ack watchdog that parks the block in JAM until cleared.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 50000,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       eject_ack,
    input  logic       clear_jam,
    output logic       eject_req,
    output logic [1:0] eject_coin,
    output logic [7:0] remaining,
    output logic [7:0] coins_dispensed,
    output logic       busy,
    output logic       done,
    output logic       jam_error
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5,
        ST_JAM     = 3'd6
    } state_t;

    function automatic logic [1:0] pick_coin(input logic [7:0] owed);
        logic [1:0] coin;
        if (owed >= 8'd5) begin
            coin = 2'b11;
        end else if (owed >= 8'd2) begin
            coin = 2'b10;
        end else begin
            coin = 2'b01;
        end
        return coin;
    endfunction

    function automatic logic [7:0] coin_value(input logic [1:0] coin);
        logic [7:0] val;
        case (coin)
            2'b01:   val = 8'd1;
            2'b10:   val = 8'd2;
            2'b11:   val = 8'd5;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       coin_q, coin_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [7:0]       coins_q, coins_d;
    logic             done_q, done_d;
    logic             eject_req_q, busy_q, jam_q;

    // Next-state and next-output logic for the dispense sequence.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        coin_d      = 2'b00;
        remaining_d = remaining_q;
        coins_d     = coins_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    coins_d     = 8'd0;
                    if (amount != 8'd0) begin
                        state_d = ST_SELECT;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                coin_d  = pick_coin(remaining_q);
                tmo_d   = '0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (eject_ack) begin
                    // Greedy choice guarantees remaining >= coin value here.
                    remaining_d = remaining_q - coin_value(coin_q);
                    coins_d     = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
                    tmo_d       = '0;
                    state_d     = ST_RELEASE;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = ST_JAM;
                end else begin
                    coin_d = coin_q;
                    tmo_d  = tmo_q + TMO_ONE;
                end
            end
            ST_RELEASE: begin
                if (!eject_ack) begin
                    gap_d = '0;
                    if (remaining_q == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = ST_JAM;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_JAM: begin
                if (clear_jam) begin
                    remaining_d = 8'd0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_JAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            gap_q       <= '0;
            coin_q      <= 2'b00;
            remaining_q <= 8'd0;
            coins_q     <= 8'd0;
            done_q      <= 1'b0;
            eject_req_q <= 1'b0;
            busy_q      <= 1'b0;
            jam_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            coin_q      <= coin_d;
            remaining_q <= remaining_d;
            coins_q     <= coins_d;
            done_q      <= done_d;
            eject_req_q <= (state_d == ST_REQ);
            busy_q      <= (state_d != ST_IDLE);
            jam_q       <= (state_d == ST_JAM);
        end
    end

    assign eject_req       = eject_req_q;
    assign eject_coin      = coin_q;
    assign remaining       = remaining_q;
    assign coins_dispensed = coins_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign jam_error       = jam_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of normal transactions plus hand-written
// sequences for zero amount, jams, ignored start and mid-handshake reset.
module tb_change_dispenser;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst, start, eject_ack, clear_jam;
    logic [7:0] amount;
    logic       eject_req, busy, done, jam_error;
    logic [1:0] eject_coin;
    logic [7:0] remaining, coins_dispensed;

    int n_tests = 0;
    int n_fail  = 0;

    int         got_n, got_done, got_unstable;
    bit         got_req, got_to;
    logic [1:0] got_coin [8];
    logic [7:0] got_rem  [8];

    typedef struct {
        logic [7:0] amt;
        int         dly;
        int         n;
        logic [1:0] coin [4];
        logic [7:0] rem  [4];
    } vec_t;

    vec_t vecs [6];

    change_dispenser #(.ACK_TIMEOUT(T), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount),
        .eject_ack(eject_ack), .clear_jam(clear_jam),
        .eject_req(eject_req), .eject_coin(eject_coin), .remaining(remaining),
        .coins_dispensed(coins_dispensed), .busy(busy), .done(done),
        .jam_error(jam_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mechanism model: acks each request after dly cycles, holds ack two cycles.
    task automatic service(input int dly);
        int req_cnt, hold;
        logic [1:0] cur;
        got_n = 0; got_done = 0; got_unstable = 0; got_req = 1'b0; got_to = 1'b1;
        req_cnt = 0; hold = 0; cur = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) got_done++;
            if (eject_req) got_req = 1'b1;
            if (hold > 0) begin
                if (hold == 2 && got_n <= 8) got_rem[got_n-1] = remaining;
                hold--;
                if (hold == 0) eject_ack = 1'b0;
            end else if (eject_req) begin
                req_cnt++;
                if (req_cnt == 1) cur = eject_coin;
                else if (eject_coin !== cur) got_unstable++;
                if (req_cnt >= dly) begin
                    if (got_n < 8) got_coin[got_n] = eject_coin;
                    got_n++;
                    eject_ack = 1'b1;
                    hold = 2;
                    req_cnt = 0;
                end
            end
            if (got_done > 0 && !busy && !done) begin
                got_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic dispense(input logic [7:0] amt, input int dly);
        @(negedge clk);
        start = 1'b1; amount = amt;
        @(negedge clk);
        start = 1'b0; amount = 8'd0;
        service(dly);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, " eject_req"}, 32'(eject_req), 32'd0);
        chk({tag, " eject_coin"}, 32'(eject_coin), 32'd0);
        chk({tag, " remaining"}, 32'(remaining), 32'd0);
        chk({tag, " coins"}, 32'(coins_dispensed), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " jam"}, 32'(jam_error), 32'd0);
    endtask

    initial begin
        vecs[0].amt = 8'd8;  vecs[0].dly = 3; vecs[0].n = 3;
        vecs[0].coin = '{2'b11, 2'b10, 2'b01, 2'b00}; vecs[0].rem = '{8'd3, 8'd1, 8'd0, 8'd0};
        vecs[1].amt = 8'd1;  vecs[1].dly = 1; vecs[1].n = 1;
        vecs[1].coin = '{2'b01, 2'b00, 2'b00, 2'b00}; vecs[1].rem = '{8'd0, 8'd0, 8'd0, 8'd0};
        vecs[2].amt = 8'd2;  vecs[2].dly = 2; vecs[2].n = 1;
        vecs[2].coin = '{2'b10, 2'b00, 2'b00, 2'b00}; vecs[2].rem = '{8'd0, 8'd0, 8'd0, 8'd0};
        vecs[3].amt = 8'd5;  vecs[3].dly = 3; vecs[3].n = 1;
        vecs[3].coin = '{2'b11, 2'b00, 2'b00, 2'b00}; vecs[3].rem = '{8'd0, 8'd0, 8'd0, 8'd0};
        vecs[4].amt = 8'd13; vecs[4].dly = 1; vecs[4].n = 4;
        vecs[4].coin = '{2'b11, 2'b11, 2'b10, 2'b01}; vecs[4].rem = '{8'd8, 8'd3, 8'd1, 8'd0};
        vecs[5].amt = 8'd4;  vecs[5].dly = 2; vecs[5].n = 2;
        vecs[5].coin = '{2'b10, 2'b10, 2'b00, 2'b00}; vecs[5].rem = '{8'd2, 8'd0, 8'd0, 8'd0};

        rst = 1'b1; start = 1'b0; amount = 8'd0; eject_ack = 1'b0; clear_jam = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_reset("reset");
        rst = 1'b0;

        // Normal transactions from the table.
        foreach (vecs[i]) begin
            dispense(vecs[i].amt, vecs[i].dly);
            chk($sformatf("v%0d timeout", i), 32'(got_to), 32'd0);
            chk($sformatf("v%0d ncoins", i), 32'(got_n), 32'(vecs[i].n));
            chk($sformatf("v%0d done_pulses", i), 32'(got_done), 32'd1);
            chk($sformatf("v%0d coin_stable", i), 32'(got_unstable), 32'd0);
            for (int k = 0; k < vecs[i].n && k < 4; k++) begin
                chk($sformatf("v%0d coin%0d", i, k), 32'(got_coin[k]), 32'(vecs[i].coin[k]));
                chk($sformatf("v%0d rem%0d", i, k), 32'(got_rem[k]), 32'(vecs[i].rem[k]));
            end
            chk($sformatf("v%0d coins_dispensed", i), 32'(coins_dispensed), 32'(vecs[i].n));
            chk($sformatf("v%0d remaining_end", i), 32'(remaining), 32'd0);
        end

        // Zero amount: immediate done, no request, not busy, count cleared.
        @(negedge clk);
        start = 1'b1; amount = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero done", 32'(done), 32'd1);
        chk("zero busy", 32'(busy), 32'd0);
        chk("zero coins", 32'(coins_dispensed), 32'd0);
        got_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (eject_req || busy || done) got_req = 1'b1;
        end
        chk("zero quiet", 32'(got_req), 32'd0);

        // Jam in REQ: no ack ever.
        @(negedge clk);
        start = 1'b1; amount = 8'd6;
        @(negedge clk);
        start = 1'b0;
        chk("jreq busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("jreq req", 32'(eject_req), 32'd1);
        chk("jreq coin", 32'(eject_coin), 32'd3);
        repeat (T - 1) @(negedge clk);
        chk("jreq not_yet", 32'(jam_error), 32'd0);
        chk("jreq req_held", 32'(eject_req), 32'd1);
        @(negedge clk);
        chk("jreq jam", 32'(jam_error), 32'd1);
        chk("jreq req_off", 32'(eject_req), 32'd0);
        chk("jreq busy_jam", 32'(busy), 32'd1);
        chk("jreq rem", 32'(remaining), 32'd6);
        repeat (3) @(negedge clk);
        chk("jreq jam_hold", 32'(jam_error), 32'd1);
        clear_jam = 1'b1;
        @(negedge clk);
        clear_jam = 1'b0;
        chk("jreq clr_jam", 32'(jam_error), 32'd0);
        chk("jreq clr_busy", 32'(busy), 32'd0);
        chk("jreq clr_rem", 32'(remaining), 32'd0);
        chk("jreq clr_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("jreq no_done", 32'(done), 32'd0);

        // Jam in RELEASE: ack stuck high after first coin.
        @(negedge clk);
        start = 1'b1; amount = 8'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("jrel coin", 32'(eject_coin), 32'd3);
        eject_ack = 1'b1;
        @(negedge clk);
        chk("jrel rem", 32'(remaining), 32'd2);
        chk("jrel coins", 32'(coins_dispensed), 32'd1);
        chk("jrel req_off", 32'(eject_req), 32'd0);
        repeat (T - 1) @(negedge clk);
        chk("jrel not_yet", 32'(jam_error), 32'd0);
        @(negedge clk);
        chk("jrel jam", 32'(jam_error), 32'd1);
        chk("jrel rem_hold", 32'(remaining), 32'd2);
        chk("jrel coins_hold", 32'(coins_dispensed), 32'd1);
        eject_ack = 1'b0;
        clear_jam = 1'b1;
        @(negedge clk);
        clear_jam = 1'b0;
        chk("jrel clr_jam", 32'(jam_error), 32'd0);
        chk("jrel clr_rem", 32'(remaining), 32'd0);

        // Second start while busy is ignored; clear_jam outside JAM has no effect.
        @(negedge clk);
        start = 1'b1; amount = 8'd4;
        @(negedge clk);
        start = 1'b1; amount = 8'd9; clear_jam = 1'b1;
        chk("ign busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; amount = 8'd0; clear_jam = 1'b0;
        service(2);
        chk("ign timeout", 32'(got_to), 32'd0);
        chk("ign ncoins", 32'(got_n), 32'd2);
        chk("ign coin0", 32'(got_coin[0]), 32'd2);
        chk("ign coin1", 32'(got_coin[1]), 32'd2);
        chk("ign coins_dispensed", 32'(coins_dispensed), 32'd2);
        chk("ign done_pulses", 32'(got_done), 32'd1);

        // Reset mid-REQ, then a normal transaction.
        @(negedge clk);
        start = 1'b1; amount = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst in_req", 32'(eject_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_reset("rst mid");
        dispense(8'd3, 3);
        chk("post timeout", 32'(got_to), 32'd0);
        chk("post ncoins", 32'(got_n), 32'd2);
        chk("post coin0", 32'(got_coin[0]), 32'd2);
        chk("post coin1", 32'(got_coin[1]), 32'd1);
        chk("post done_pulses", 32'(got_done), 32'd1);
        chk("post coins_dispensed", 32'(coins_dispensed), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
